// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two byte-enabled write ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_mp #(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  DEPTH    = 32,
    parameter int unsigned  NUM_RD   = 2,
    parameter int unsigned  ZERO_REG = 1,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned BE_W     = WIDTH / 8
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*WIDTH-1:0]  ReadData,
    input  logic                     RegWrite0,
    input  logic [ADDR_W-1:0]        WriteRegister0,
    input  logic [WIDTH-1:0]         WriteData0,
    input  logic [BE_W-1:0]          ByteEn0,
    input  logic                     RegWrite1,
    input  logic [ADDR_W-1:0]        WriteRegister1,
    input  logic [WIDTH-1:0]         WriteData1,
    input  logic [BE_W-1:0]          ByteEn1
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok0;
    logic             w_wr_ok1;

    // Address is backed by storage and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_wr_ok0 = RegWrite0 && addr_ok(WriteRegister0);
    assign w_wr_ok1 = RegWrite1 && addr_ok(WriteRegister1);

    // Port 1 updates are scheduled after port 0, so port 1 wins on shared bytes.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (w_wr_ok0 && ByteEn0[b]) begin
                    r_mem[WriteRegister0][b*8 +: 8] <= WriteData0[b*8 +: 8];
                end
                if (w_wr_ok1 && ByteEn1[b]) begin
                    r_mem[WriteRegister1][b*8 +: 8] <= WriteData1[b*8 +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [WIDTH-1:0]  w_rd;

        assign w_ra = ReadRegister[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = '0;
            if (Rst_n && addr_ok(w_ra)) begin
                w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (w_wr_ok0 && (WriteRegister0 == w_ra) && ByteEn0[b]) begin
                        w_rd[b*8 +: 8] = WriteData0[b*8 +: 8];
                    end
                    if (w_wr_ok1 && (WriteRegister1 == w_ra) && ByteEn1[b]) begin
                        w_rd[b*8 +: 8] = WriteData1[b*8 +: 8];
                    end
                end
`endif
            end
        end

        assign ReadData[k*WIDTH +: WIDTH] = w_rd;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: expected read values are queued on a scoreboard
// when stimulus is driven and compared against ReadData before/after clock edges.
module tb_register_file_mp;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned BE_W   = 4;

    logic                     Clk = 1'b0;
    logic                     Rst_n;
    logic [NUM_RD*ADDR_W-1:0] ReadRegister;
    logic [NUM_RD*WIDTH-1:0]  ReadData;
    logic                     RegWrite0;
    logic [ADDR_W-1:0]        WriteRegister0;
    logic [WIDTH-1:0]         WriteData0;
    logic [BE_W-1:0]          ByteEn0;
    logic                     RegWrite1;
    logic [ADDR_W-1:0]        WriteRegister1;
    logic [WIDTH-1:0]         WriteData1;
    logic [BE_W-1:0]          ByteEn1;

    register_file_mp #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ReadRegister   (ReadRegister),
        .ReadData       (ReadData),
        .RegWrite0      (RegWrite0),
        .WriteRegister0 (WriteRegister0),
        .WriteData0     (WriteData0),
        .ByteEn0        (ByteEn0),
        .RegWrite1      (RegWrite1),
        .WriteRegister1 (WriteRegister1),
        .WriteData1     (WriteData1),
        .ByteEn1        (ByteEn1)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          port;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [ADDR_W-1:0] a);
        ReadRegister[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic expect_rd(input int p, input logic [31:0] v, input string tag);
        exp_t e;
        e.port = p;
        e.val  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = ReadData[e.port*WIDTH +: WIDTH];
            n_checks++;
            assert (obs === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr0(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        RegWrite0 = 1'b1; WriteRegister0 = a; WriteData0 = d; ByteEn0 = be;
    endtask

    task automatic wr1(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        RegWrite1 = 1'b1; WriteRegister1 = a; WriteData1 = d; ByteEn1 = be;
    endtask

    task automatic model_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        if (a != '0) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    // Apply pending writes to the model (port 1 last), clock them in, then idle the ports.
    task automatic commit();
        if (RegWrite0) model_wr(WriteRegister0, WriteData0, ByteEn0);
        if (RegWrite1) model_wr(WriteRegister1, WriteData1, ByteEn1);
        tick();
        RegWrite0 = 1'b0;
        RegWrite1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        Rst_n = 1'b0;
        ReadRegister = '0;
        RegWrite0 = 1'b0; WriteRegister0 = '0; WriteData0 = '0; ByteEn0 = '0;
        RegWrite1 = 1'b0; WriteRegister1 = '0; WriteData1 = '0; ByteEn1 = '0;

        // Reset state
        rd(0, 5'd5); rd(1, 5'd31);
        expect_rd(0, 32'h0, "reset_rd0");
        expect_rd(1, 32'h0, "reset_rd1");
        check();
        @(negedge Clk);
        Rst_n = 1'b1;

        // Async reset clears r5 between edges
        wr0(5'd5, 32'hDEADBEEF, 4'hF);
        commit();
        rd(0, 5'd5); rd(1, 5'd5);
        expect_rd(0, 32'hDEADBEEF, "r5_written");
        check();
        #2;
        Rst_n = 1'b0;
        model[5] = '0;
        expect_rd(0, 32'h0, "r5_async_clear_p0");
        expect_rd(1, 32'h0, "r5_async_clear_p1");
        check();
        wr0(5'd5, 32'hCAFEF00D, 4'hF);
        expect_rd(0, 32'h0, "reset_blocks_bypass");
        check();
        tick();
        expect_rd(0, 32'h0, "reset_blocks_write");
        check();
        RegWrite0 = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        expect_rd(1, 32'h0, "r5_after_release");
        check();

        // Basic write/read
        wr0(5'd8, 32'd42, 4'hF);
        commit();
        wr0(5'd9, 32'd52, 4'hF);
        commit();
        rd(0, 5'd8); rd(1, 5'd9);
        expect_rd(0, 32'd42, "r8_basic");
        expect_rd(1, 32'd52, "r9_basic");
        check();

        // Sweep r8..r25
        for (int a = 8; a <= 25; a++) begin
            wr0(5'(a), $urandom, 4'hF);
            commit();
        end
        for (int a = 8; a <= 25; a += 2) begin
            rd(0, 5'(a)); rd(1, 5'(a + 1));
            expect_rd(0, model[a], "sweep_p0");
            expect_rd(1, model[a + 1], "sweep_p1");
            check();
        end

        // Zero register on both ports
        wr0(5'd0, 32'h12345678, 4'hF);
        wr1(5'd0, 32'h12345678, 4'hF);
        rd(0, 5'd0); rd(1, 5'd0);
        expect_rd(0, 32'h0, "r0_before_edge");
        expect_rd(1, 32'h0, "r0_before_edge_p1");
        check();
        commit();
        expect_rd(0, 32'h0, "r0_after_edge");
        check();

        // Dual write to r10, port 1 wins on shared bytes
        wr0(5'd10, 32'hAAAAAAAA, 4'b1111);
        wr1(5'd10, 32'h55555555, 4'b0011);
        rd(0, 5'd10);
`ifdef REGFILE_BYPASS_EN
        expect_rd(0, 32'hAAAA5555, "r10_dual_bypass");
`else
        expect_rd(0, model[10], "r10_dual_no_bypass");
`endif
        check();
        commit();
        expect_rd(0, 32'hAAAA5555, "r10_dual_write");
        check();

        // Byte enable on r11
        wr0(5'd11, 32'h11223344, 4'hF);
        commit();
        wr0(5'd11, 32'hFFFFFFFF, 4'b1000);
        commit();
        rd(1, 5'd11);
        expect_rd(1, 32'hFF223344, "r11_byte_en");
        check();

        // Disjoint bytes from both ports on r14; zero byte-enable on r13 is a no-op
        wr0(5'd14, 32'hA1B2C3D4, 4'b1100);
        wr1(5'd14, 32'h11223344, 4'b0011);
        commit();
        rd(0, 5'd14);
        expect_rd(0, 32'hA1B23344, "r14_merge");
        check();
        wr1(5'd13, 32'h0BADBEEF, 4'b0000);
        commit();
        rd(1, 5'd13);
        expect_rd(1, model[13], "r13_be_zero_noop");
        check();

        // Bypass on r12
        wr0(5'd12, 32'd7, 4'hF);
        commit();
        wr0(5'd12, 32'd99, 4'hF);
        rd(0, 5'd12); rd(1, 5'd12);
`ifdef REGFILE_BYPASS_EN
        expect_rd(0, 32'd99, "r12_bypass_before_edge");
`else
        expect_rd(0, 32'd7, "r12_no_bypass_before_edge");
`endif
        check();
        commit();
        expect_rd(0, 32'd99, "r12_after_edge_p0");
        expect_rd(1, 32'd99, "r12_after_edge_p1");
        check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the processor datapath; next generation of the two-read/one-write `RegisterFile`. Provides `NUM_RD` combinational read ports and two clocked write ports with byte enables, a hardwired zero register, async clear, and optional same-cycle write-to-read bypass. Sits in the decode stage; write port 0 serves the main writeback path and write port 1 a second issue slot or load return.

## Interface
- `WIDTH`, 32, data width in bits; must be a multiple of 8.
- `DEPTH`, 32, number of registers; 2..256.
- `NUM_RD`, 2, number of read ports; 1..8.
- `ZERO_REG`, 1, if 1 register 0 always reads 0 and ignores writes.
- Derived: `ADDR_W` = `$clog2(DEPTH)`; `BE_W` = `WIDTH/8`.

- `Clk`  in  1  clock; all state updates on rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `ReadRegister`  in  `NUM_RD*ADDR_W`  read addresses; port k at bits `[k*ADDR_W +: ADDR_W]`.
- `ReadData`  out  `NUM_RD*WIDTH`  read data; port k at bits `[k*WIDTH +: WIDTH]`.
- `RegWrite0`  in  1  write enable, port 0.
- `WriteRegister0`  in  `ADDR_W`  write address, port 0.
- `WriteData0`  in  `WIDTH`  write data, port 0.
- `ByteEn0`  in  `BE_W`  byte enables, port 0; bit b covers bits `[8b+7:8b]`.
- `RegWrite1`, `WriteRegister1`, `WriteData1`, `ByteEn1`: same as port 0, for port 1.

## Operation
- Storage: `DEPTH` registers of `WIDTH` bits.
- Write: on rising `Clk`, if `RegWriteN`=1, each byte of `WriteRegisterN` with `ByteEnN[b]`=1 takes `WriteDataN[8b+7:8b]`; bytes with enable 0 keep their value. `ByteEnN`=0 with `RegWriteN`=1 is a no-op.
- Same-address dual write: merged per byte; where both ports enable a byte, port 1 wins. Bytes enabled by only one port take that port's data.
- Zero register (`ZERO_REG`=1): writes to address 0 are discarded; every read of address 0 returns 0, including via bypass.
- Out-of-range address (`DEPTH` not a power of two, address >= `DEPTH`): writes ignored, reads return 0.
- Read: purely combinational; `ReadData` port k = contents of `ReadRegister` port k. Any number of ports may read the same address.
- Reset: `Rst_n` low clears every register to 0 immediately, with no clock needed. While low, writes are blocked and all `ReadData` = 0, bypass included. Reset asserted mid-write: the write is lost.
- Reset release: first write accepted on the first rising `Clk` with `Rst_n` high.

## Timing
- Read latency 0 cycles from address change (combinational path).
- Write latency 1 edge: data written at edge t is visible on reads after edge t. With bypass enabled, it is also visible in the cycle before edge t.
- No handshake; ports always ready and writes cannot stall.
- Reset: asynchronous assert. Deassertion is expected synchronous to `Clk` from the system reset synchroniser; the block does not resynchronise it.

## Configuration
- `REGFILE_BYPASS_EN` defined: when a read address equals an enabled write address in the same cycle (not a discarded zero-register or out-of-range write), `ReadData` returns the merged next value. That is the current contents overlaid with the port-0 bytes, then the port-1 bytes, per the rules above. This is a combinational path from `WriteData*` to `ReadData`.
- Not defined: reads always return stored contents. The new value appears only after the clock edge, and there is no combinational path from the write ports to `ReadData`.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse `Rst_n` low between clock edges. Required: r5 reads 0 immediately, before the next edge, and all `ReadData` = 0 while `Rst_n` is low.
- Basic write/read: write 42 to r8 and 52 to r9 via port 0 on consecutive cycles, then read r8/r9 on ports 0/1. Required: 42 and 52. Sweep r8..r25 with arbitrary values, reading them back two at a time.
- Zero register: write 0x12345678 to r0 on both ports. Required: r0 reads 0 before and after the edge, with and without the macro.
- Dual write, same address: port 0 writes 0xAAAAAAAA with `ByteEn0`=1111 and port 1 writes 0x55555555 with `ByteEn1`=0011, both to r10. Required: r10 = 0xAAAA5555 after the edge.
- Byte enable: r11 = 0x11223344, then port 0 writes 0xFFFFFFFF with `ByteEn0`=1000. Required: 0xFF223344.
- Bypass: r12 = 7; in one cycle write 99 to r12 while reading r12. Required before the edge: 99 with `REGFILE_BYPASS_EN` defined, 7 without. Both builds read 99 after the edge.
